ham_serial_rx: RTL and testbench
================================

HAM_SERIAL_RX -- requirements
Module: ham_serial_rx

Interface
REQ-001 Parameter: CNT_W, 8, width of the saturating error counters.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ser_in  in  1  serial codeword bit, LSB (code bit 0) first.
REQ-006 ser_valid  in  1  ser_in is sampled on this clock edge.
REQ-007 frm_start  in  1  qualified by ser_valid; the current bit is bit 0 of a new frame.
REQ-008 o_data  out  4  decoded nibble {d3,d2,d1,d0}.
REQ-009 o_syn  out  3  syndrome {z4,z2,z1} of the delivered frame.
REQ-010 o_corr / o_dbl  out  1 each  single error corrected / double error detected.
REQ-011 o_valid  out 1, o_ready  in 1  output handshake; a transfer occurs when both are high.
REQ-012 corr_cnt / dbl_cnt  out  CNT_W  saturating counts of corrected and double-error frames.
REQ-013 ovr_flag / abort_flag  out  1  sticky overrun and aborted-frame flags.
REQ-014 clr_stat  in  1  synchronous clear of the counters and sticky flags.

Function
REQ-015 Codeword layout: code[6:0] = {d3,d2,d1,p4,d0,p2,p1}.
  - z1 = c0^c2^c4^c6
  - z2 = c1^c2^c5^c6
  - z4 = c3^c4^c5^c6
REQ-016 A non-zero syndrome s SHALL flip code bit s-1 before data is extracted from bits 6,5,4,2.
REQ-017 FSM states:
  - IDLE: ser_valid without frm_start is ignored; frm_start&ser_valid loads bit 0 and moves to SHIFT.
  - SHIFT: each ser_valid loads the next bit; when the final bit is loaded, the frame is decoded and the FSM returns to IDLE.
REQ-018 frm_start&ser_valid in SHIFT SHALL discard the partial frame, set abort_flag, and restart with the current bit as bit 0.
REQ-019 Latency: o_valid, o_data, o_syn, o_corr and o_dbl SHALL be registered and valid in the cycle after the edge that samples the final bit.
REQ-020 The output register is single-entry; it SHALL hold until o_valid&o_ready, and a new frame may shift in meanwhile.
REQ-021 Overrun: if a frame completes while o_valid=1 and o_ready=0:
  - the new frame is dropped and ovr_flag is set;
  - the held output is unchanged.
REQ-022 A frame completing in the same cycle the held output transfers SHALL load normally, with no overrun.
REQ-023 Each delivered frame SHALL increment corr_cnt if o_corr is set and dbl_cnt if o_dbl is set; both saturate at 2^CNT_W-1.
REQ-024 clr_stat SHALL take priority over a simultaneous increment or flag set.

Reset
REQ-025 rst_n low SHALL asynchronously force:
  - FSM to IDLE and the bit index to 0;
  - o_valid=0, o_data=0, o_syn=0, o_corr=0, o_dbl=0;
  - counters=0, ovr_flag=0, abort_flag=0.
REQ-026 Reset mid-frame discards the partial frame; the first frame after reset requires frm_start.

Configuration
REQ-027 Macro HAM_SECDED_EN defined: the frame is 8 bits, and bit 7 = p8 = XOR of code[6:0].
  - Overall check q = XOR of all 8 bits.
  - s!=0, q=1: correct bit s-1, o_corr=1.
  - s=0, q=1: p8 error only; data intact, o_corr=1.
  - s!=0, q=0: o_dbl=1, data passed uncorrected, o_corr=0.
REQ-028 Macro HAM_SECDED_EN undefined: the frame is 7 bits; o_dbl and dbl_cnt are tied to 0; any s!=0 is corrected.

Structure
REQ-029 Package ham_pkg SHALL hold:
  - the codeword bit-index constants;
  - the syndrome type (3-bit);
  - the frame-length constant, selected by HAM_SECDED_EN.
REQ-030 Syndrome computation and correction SHALL live in a combinational sub-module ham74_syn_corr; the FSM, output register and counters live in ham_serial_rx.

Verification
REQ-031 Clean frame for data 4'hB (code 7'b1010101, sent 1,0,1,0,1,0,1) -> o_data=4'hB, o_syn=3'b000, o_corr=0, one cycle after the last bit.
REQ-032 Same frame with code bit 4 flipped (7'b1000101) -> o_syn=3'b101, o_data=4'hB, o_corr=1, corr_cnt=1.
REQ-033 HAM_SECDED_EN, frame 8'b01010101 with bits 0 and 1 flipped -> o_syn=3'b011, o_dbl=1, o_corr=0, o_data=4'hB, dbl_cnt=1.
REQ-034 o_ready=0, two clean frames (4'hB then 4'h3) -> o_data stays 4'hB, ovr_flag=1; after o_ready=1, one transfer of 4'hB only.
REQ-035 frm_start after 3 bits, then a full clean 4'h3 frame -> abort_flag=1, o_data=4'h3; 256 corrected frames -> corr_cnt=255; clr_stat -> all counters and flags 0.
REQ-036 rst_n pulsed after 4 bits of a frame -> all outputs 0; the next complete frame decodes correctly.

Source files
------------

// File: rtl/ham_pkg.sv
// ham_pkg: codeword bit positions, syndrome/state types and frame length.
// Defining HAM_SECDED_EN selects the 8-bit SECDED frame (extra overall parity bit p8).
package ham_pkg;
    localparam int unsigned BIT_P1 = 0;
    localparam int unsigned BIT_P2 = 1;
    localparam int unsigned BIT_D0 = 2;
    localparam int unsigned BIT_P4 = 3;
    localparam int unsigned BIT_D1 = 4;
    localparam int unsigned BIT_D2 = 5;
    localparam int unsigned BIT_D3 = 6;
    localparam int unsigned BIT_P8 = 7;
`ifdef HAM_SECDED_EN
    localparam int unsigned FRAME_LEN = 8;
`else
    localparam int unsigned FRAME_LEN = 7;
`endif
    localparam int unsigned IDX_W = 3;
    typedef logic [2:0] syn_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
endpackage

// File: rtl/ham74_syn_corr.sv
// ham74_syn_corr: combinational Hamming(7,4) syndrome, single-bit correction and data extraction.
// With HAM_SECDED_EN the overall parity bit separates single from double errors.
module ham74_syn_corr
    import ham_pkg::*;
(
    input  logic [FRAME_LEN-1:0] code_i,
    output logic [3:0]           data_o,
    output syn_t                 syn_o,
    output logic                 corr_o,
    output logic                 dbl_o
);
    logic       do_fix;
    logic [6:0] flip;
    logic [6:0] fixed;

    assign syn_o[0] = code_i[BIT_P1] ^ code_i[BIT_D0] ^ code_i[BIT_D1] ^ code_i[BIT_D3];
    assign syn_o[1] = code_i[BIT_P2] ^ code_i[BIT_D0] ^ code_i[BIT_D2] ^ code_i[BIT_D3];
    assign syn_o[2] = code_i[BIT_P4] ^ code_i[BIT_D1] ^ code_i[BIT_D2] ^ code_i[BIT_D3];

`ifdef HAM_SECDED_EN
    logic q;
    // q=1 means an odd number of flips: correctable (s=0 means only p8 was hit)
    assign q      = ^code_i;
    assign do_fix = q && (syn_o != 3'd0);
    assign corr_o = q;
    assign dbl_o  = !q && (syn_o != 3'd0);
`else
    assign do_fix = (syn_o != 3'd0);
    assign corr_o = do_fix;
    assign dbl_o  = 1'b0;
`endif

    assign flip   = do_fix ? (7'd1 << (syn_o - 3'd1)) : 7'd0;
    assign fixed  = code_i[6:0] ^ flip;
    assign data_o = {fixed[BIT_D3], fixed[BIT_D2], fixed[BIT_D1], fixed[BIT_D0]};
endmodule

// File: rtl/ham_serial_rx.sv
// ham_serial_rx: serial Hamming frame receiver with single-entry output register and error statistics.
// HAM_SECDED_EN selects the 8-bit SECDED frame and enables double-error detection/counting.
module ham_serial_rx
    import ham_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frm_start,
    output logic [3:0]       o_data,
    output logic [2:0]       o_syn,
    output logic             o_corr,
    output logic             o_dbl,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] dbl_cnt,
    output logic             ovr_flag,
    output logic             abort_flag,
    input  logic             clr_stat
);
    state_t                 state_q, state_d;
    idx_t                   idx_q, idx_d;
    logic [FRAME_LEN-1:0]   sr_q, sr_d, frame;
    logic                   done, abort_set, xfer, load, ovr_set;
    logic [3:0]             dec_data, data_q;
    syn_t                   dec_syn, syn_q;
    logic                   dec_corr, dec_dbl, corr_q, dbl_q, valid_q;
    logic [CNT_W-1:0]       corr_cnt_q;
    logic                   ovr_q, abort_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sr_d        = sr_q;
        frame       = sr_q;
        frame[idx_q] = ser_in;
        done        = 1'b0;
        abort_set   = 1'b0;
        if (ser_valid) begin
            if (frm_start) begin
                abort_set = (state_q == ST_SHIFT);
                sr_d      = '0;
                sr_d[0]   = ser_in;
                idx_d     = idx_t'(1);
                state_d   = ST_SHIFT;
            end else if (state_q == ST_SHIFT) begin
                sr_d    = frame;
                done    = (idx_q == idx_t'(FRAME_LEN - 1));
                idx_d   = done ? '0 : idx_q + 1'b1;
                state_d = done ? ST_IDLE : ST_SHIFT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
        end
    end

    ham74_syn_corr u_dec (
        .code_i (frame),
        .data_o (dec_data),
        .syn_o  (dec_syn),
        .corr_o (dec_corr),
        .dbl_o  (dec_dbl)
    );

    // A completing frame may load in the same cycle the held entry leaves
    assign xfer    = valid_q & o_ready;
    assign load    = done & (~valid_q | o_ready);
    assign ovr_set = done & valid_q & ~o_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            syn_q   <= '0;
            corr_q  <= 1'b0;
            dbl_q   <= 1'b0;
        end else begin
            valid_q <= load | (valid_q & ~o_ready);
            if (load) begin
                data_q <= dec_data;
                syn_q  <= dec_syn;
                corr_q <= dec_corr;
                dbl_q  <= dec_dbl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q <= '0;
            ovr_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else if (clr_stat) begin
            corr_cnt_q <= '0;
            ovr_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            if (xfer && corr_q && corr_cnt_q != '1)
                corr_cnt_q <= corr_cnt_q + 1'b1;
            ovr_q   <= ovr_q | ovr_set;
            abort_q <= abort_q | abort_set;
        end
    end

`ifdef HAM_SECDED_EN
    logic [CNT_W-1:0] dbl_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dbl_cnt_q <= '0;
        else if (clr_stat)
            dbl_cnt_q <= '0;
        else if (xfer && dbl_q && dbl_cnt_q != '1)
            dbl_cnt_q <= dbl_cnt_q + 1'b1;
    end
    assign dbl_cnt = dbl_cnt_q;
`else
    assign dbl_cnt = '0;
`endif

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_syn      = syn_q;
    assign o_corr     = corr_q;
    assign o_dbl      = dbl_q;
    assign corr_cnt   = corr_cnt_q;
    assign ovr_flag   = ovr_q;
    assign abort_flag = abort_q;
endmodule

// File: tb/tb_ham_serial_rx.sv
// tb_ham_serial_rx: table-driven and scoreboard-checked bench for ham_serial_rx.
// Follows HAM_SECDED_EN to choose the 7- or 8-bit frame.
module tb_ham_serial_rx;
`ifdef HAM_SECDED_EN
    localparam int FL = 8;
`else
    localparam int FL = 7;
`endif
    logic       clk = 0, rst_n = 0, ser_in = 0, ser_valid = 0, frm_start = 0, o_ready = 0, clr_stat = 0;
    logic [3:0] o_data;
    logic [2:0] o_syn;
    logic       o_corr, o_dbl, o_valid, ovr_flag, abort_flag;
    logic [7:0] corr_cnt, dbl_cnt;

    ham_serial_rx #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .frm_start(frm_start),
        .o_data(o_data), .o_syn(o_syn), .o_corr(o_corr), .o_dbl(o_dbl), .o_valid(o_valid),
        .o_ready(o_ready), .corr_cnt(corr_cnt), .dbl_cnt(dbl_cnt), .ovr_flag(ovr_flag),
        .abort_flag(abort_flag), .clr_stat(clr_stat)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [3:0] data; logic [2:0] syn; logic corr; logic dbl;} exp_t;
    typedef struct {logic [3:0] d; logic [7:0] flip; exp_t e;} vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   checks = 0, failures = 0, ncorr = 0, ndbl = 0;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [7:0] enc(logic [3:0] d);
        logic [7:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[7] = ^c[6:0];
        return c;
    endfunction

    task automatic push(exp_t e);
        sb.push_back(e);
        ncorr += int'(e.corr);
        ndbl  += int'(e.dbl);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] f, int lo, int hi, logic start, logic gap);
        for (int i = lo; i < hi; i++) begin
            if (gap && i == lo + 2) begin
                ser_valid = 0; frm_start = 0; ser_in = ~ser_in;
                @(posedge clk); #1;
            end
            ser_valid = 1; ser_in = f[i]; frm_start = start && (i == lo);
            @(posedge clk); #1;
        end
        ser_valid = 0; frm_start = 0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && o_valid && o_ready) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output: got data %0h with no frame expected", o_data);
            end else begin
                e = sb.pop_front();
                chk("frame{data,syn,corr,dbl}", {23'd0, o_data, o_syn, o_corr, o_dbl}, {23'd0, e});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 16; d += 5) vt.push_back('{4'(d), 8'h00, exp_t'{4'(d), 3'd0, 1'b0, 1'b0}});
        for (int k = 0; k < 7; k++) vt.push_back('{4'(6 ^ k), 8'h01 << k, exp_t'{4'(6 ^ k), 3'(k + 1), 1'b1, 1'b0}});
`ifdef HAM_SECDED_EN
        vt.push_back('{4'h9, 8'h80, exp_t'{4'h9, 3'd0, 1'b1, 1'b0}});
        vt.push_back('{4'hB, 8'h03, exp_t'{4'hB, 3'd3, 1'b0, 1'b1}});
        vt.push_back('{4'h5, 8'h09, exp_t'{4'h5, 3'd5, 1'b0, 1'b1}});
        vt.push_back('{4'hC, 8'h0A, exp_t'{4'hC, 3'd6, 1'b0, 1'b1}});
`endif
        idle(2);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_syn_corr_dbl", {o_syn, o_corr, o_dbl}, 0);
        chk("rst_counters", {corr_cnt, dbl_cnt}, 0);
        chk("rst_flags", {ovr_flag, abort_flag}, 0);
        #3 rst_n = 1;
        idle(1);
        o_ready = 1;

        push(exp_t'{4'hB, 3'd0, 1'b0, 1'b0});
        send(enc(4'hB), 0, FL - 1, 1, 0);
        chk("latency_before_last", o_valid, 0);
        send(enc(4'hB), FL - 1, FL, 0, 0);
        chk("latency_valid", o_valid, 1);
        chk("latency_data", {o_data, o_syn, o_corr}, {4'hB, 3'd0, 1'b0});
        idle(2);

        push(exp_t'{4'hB, 3'd5, 1'b1, 1'b0});
        send(enc(4'hB) ^ 8'h10, 0, FL, 1, 0);
        idle(2);
        chk("corr_cnt_single", corr_cnt, 1);

        for (int i = 0; i < vt.size(); i++) begin
            push(vt[i].e);
            send(enc(vt[i].d) ^ vt[i].flip, 0, FL, 1, i[0]);
            idle(1);
        end
        idle(2);
        chk("corr_cnt_table", corr_cnt, 8'(ncorr));
        chk("dbl_cnt_table", dbl_cnt, 8'(ndbl));

        clr_stat = 1; idle(1); clr_stat = 0;
        for (int i = 0; i < 256; i++) begin
            push(exp_t'{4'(i), 3'((i % 7) + 1), 1'b1, 1'b0});
            send(enc(4'(i)) ^ (8'h01 << (i % 7)), 0, FL, 1, 0);
            idle(1);
        end
        idle(2);
        chk("corr_cnt_saturated", corr_cnt, 255);
        chk("dbl_cnt_after_clear", dbl_cnt, 0);

        clr_stat = 1; idle(1); clr_stat = 0;
        o_ready = 0;
        push(exp_t'{4'hB, 3'd0, 1'b0, 1'b0});
        send(enc(4'hB), 0, FL, 1, 0);
        idle(2);
        chk("held_valid", o_valid, 1);
        push(exp_t'{4'h3, 3'd0, 1'b0, 1'b0});
        send(enc(4'h3), 0, FL - 1, 1, 0);
        o_ready = 1;
        send(enc(4'h3), FL - 1, FL, 0, 0);
        idle(2);
        chk("same_cycle_no_ovr", ovr_flag, 0);
        chk("same_cycle_drained", o_valid, 0);

        o_ready = 0;
        push(exp_t'{4'hB, 3'd0, 1'b0, 1'b0});
        send(enc(4'hB), 0, FL, 1, 0);
        send(enc(4'h3), 0, FL, 1, 0);
        idle(2);
        chk("ovr_data_held", o_data, 4'hB);
        chk("ovr_flag", ovr_flag, 1);
        o_ready = 1;
        idle(3);
        chk("ovr_single_transfer", o_valid, 0);
        chk("ovr_sb_empty", sb.size(), 0);

        send(enc(4'h5), 0, 3, 1, 0);
        push(exp_t'{4'h3, 3'd0, 1'b0, 1'b0});
        send(enc(4'h3), 0, FL, 1, 0);
        idle(2);
        chk("abort_flag", abort_flag, 1);
        push(exp_t'{4'h7, 3'd2, 1'b1, 1'b0});
        send(enc(4'h7) ^ 8'h02, 0, FL, 1, 0);
        idle(2);
        chk("pre_clear_corr", corr_cnt, 1);
        clr_stat = 1; idle(1); clr_stat = 0;
        chk("clr_counters", {corr_cnt, dbl_cnt}, 0);
        chk("clr_flags", {ovr_flag, abort_flag}, 0);

        o_ready = 0;
        send(enc(4'h5), 0, FL, 1, 0);
        send(enc(4'h9), 0, FL, 1, 0);
        send(enc(4'hB), 0, 4, 1, 0);
        #2 rst_n = 0;
        #2;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_outputs", {o_data, o_syn, o_corr, o_dbl}, 0);
        chk("midrst_stats", {corr_cnt, dbl_cnt, ovr_flag, abort_flag}, 0);
        #2 rst_n = 1;
        idle(1);
        o_ready = 1;
        send(enc(4'hB), 4, FL, 0, 0);
        idle(2);
        chk("no_frame_without_start", o_valid, 0);
        push(exp_t'{4'hB, 3'd0, 1'b0, 1'b0});
        send(enc(4'hB), 0, FL, 1, 0);
        idle(3);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
